// File: rtl/dmem_pkg.sv
// Shared types and helpers for the CPU data-memory responder.
package dmem_pkg;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h1001_0000;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP,
    S_DONE
  } state_t;

  // Little-endian lane merge: bytes use lane[1:0], halves use lane[1].
  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_word,
    input logic [31:0] wd,
    input logic [1:0]  lane,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = old_word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port word RAM with registered read data.
module dmem_ram #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: loads, word stores and sub-word read-modify-write stores.
// Define DMEM_ERR_EN to enable range/alignment faults reported on addr_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = DEFAULT_ADDR_BASE,
  parameter int          DEPTH_WORDS  = 2048,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic        special_store_signal,
  input  logic        store_byte,
  output logic [31:0] dmem_data,
  output logic        dmem_ready,
  output logic        addr_err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t          state, state_nx;
  logic [31:0]     offset;
  logic [IW-1:0]   idx_in, idx_q, ram_addr;
  logic [1:0]      size_in, size_q, lane_q;
  logic            fault_in, accept, op_load_q, err_q;
  logic [31:0]     wdata_q, data_q, ram_wdata, ram_rdata;
  logic            ram_we;
  logic [CW-1:0]   rd_cnt;

  assign offset  = data_addr - ADDR_BASE;
  assign idx_in  = offset[IW+1:2];
  assign size_in = (dmem_w && special_store_signal) ? (store_byte ? SZ_BYTE : SZ_HALF) : SZ_WORD;

`ifdef DMEM_ERR_EN
  assign fault_in = (|offset[31:IW+2])
                  | ((size_in == SZ_WORD) & (|offset[1:0]))
                  | ((size_in == SZ_HALF) & offset[0]);
`else
  // Without checks the index simply wraps; the high offset bits are ignored.
  logic unused_hi;
  assign unused_hi = ^offset[31:IW+2];
  assign fault_in  = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = wdata_q;
    case (state)
      S_IDLE: begin
        if (dmem_r || dmem_w) begin
          accept = 1'b1;
          if (fault_in)                 state_nx = S_RESP;
          else if (dmem_w)              state_nx = (size_in == SZ_WORD) ? S_WR : S_RMW_RD;
          else if (READ_LATENCY > 1)    state_nx = S_RD_WAIT;
          else                          state_nx = S_RESP;
        end
      end
      S_RD_WAIT: if (int'(rd_cnt) + 2 >= READ_LATENCY) state_nx = S_RESP;
      S_WR: begin
        ram_we   = 1'b1;
        state_nx = S_RESP;
      end
      S_RMW_RD: state_nx = S_RMW_WR;
      S_RMW_WR: begin
        ram_we    = 1'b1;
        ram_wdata = lane_merge(ram_rdata, wdata_q, lane_q, size_q);
        state_nx  = S_RESP;
      end
      S_RESP:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      op_load_q <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_WORD;
      lane_q    <= 2'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_cnt    <= '0;
      data_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_load_q <= ~dmem_w;
        err_q     <= fault_in;
        size_q    <= size_in;
        lane_q    <= offset[1:0];
        idx_q     <= idx_in;
        wdata_q   <= w_data;
        rd_cnt    <= '0;
      end
      if (state == S_RD_WAIT) rd_cnt <= rd_cnt + 1'b1;
      if (state == S_RESP && op_load_q && !err_q) data_q <= ram_rdata;
    end
  end

  // In IDLE the RAM already reads the incoming index so a 1-cycle load works.
  assign ram_addr = (state == S_IDLE) ? idx_in : idx_q;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign dmem_ready = (state == S_RESP);
  assign dmem_data  = (dmem_ready && op_load_q && !err_q) ? ram_rdata : data_q;
`ifdef DMEM_ERR_EN
  assign addr_err   = dmem_ready & err_q;
`else
  assign addr_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; expectations follow DMEM_ERR_EN when defined.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;

`ifdef DMEM_ERR_EN
  localparam int          ERR_LAT   = 1;
  localparam logic        ERR_FLAG  = 1'b1;
  localparam int          SH_LAT    = 1;
  localparam logic [31:0] W0_AFTER  = 32'hCAFEF00D;
  localparam logic [31:0] W16_AFTER = 32'hAABBCCDD;
`else
  localparam int          ERR_LAT   = 2;
  localparam logic        ERR_FLAG  = 1'b0;
  localparam int          SH_LAT    = 3;
  localparam logic [31:0] W0_AFTER  = 32'h55555555;
  localparam logic [31:0] W16_AFTER = 32'hAABB7777;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] data_addr, w_data;
  logic        dmem_r, dmem_w, special_store_signal, store_byte;
  logic [31:0] dmem_data;
  logic        dmem_ready, addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .data_addr            (data_addr),
    .w_data               (w_data),
    .dmem_r               (dmem_r),
    .dmem_w               (dmem_w),
    .special_store_signal (special_store_signal),
    .store_byte           (store_byte),
    .dmem_data            (dmem_data),
    .dmem_ready           (dmem_ready),
    .addr_err             (addr_err)
  );

  task automatic idle_inputs();
    dmem_r = 1'b0; dmem_w = 1'b0; special_store_signal = 1'b0; store_byte = 1'b0;
    data_addr = '0; w_data = '0;
  endtask

  // Holds the request until dmem_ready, then waits out RESP and DONE.
  task automatic access(input logic r, input logic w, input logic sp, input logic sb,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    data_addr = addr; w_data = wd; dmem_r = r; dmem_w = w;
    special_store_signal = sp; store_byte = sb;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dmem_ready) begin
        lat = i; rd = dmem_data; er = addr_err;
        break;
      end
    end
    idle_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #1;
    checks++; if (dmem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", dmem_ready); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", addr_err); end
    checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dmem_data); end
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er;
    access(0, 1, 0, 0, BASE + 8, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b want 0", er); end
    access(1, 0, 0, 0, BASE + 8, 32'h0, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_err: got %b want 0", er); end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] rd; logic er;
    access(0, 1, 1, 1, BASE + 9, 32'h0000_00A5, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_lat: got %0d want 3", lat); end
    access(1, 0, 0, 0, BASE + 8, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEADA5EF) begin errors++; $display("FAIL sb_data: got %h want deada5ef", rd); end
    access(0, 1, 0, 0, BASE + 8, 32'hDEADBEEF, lat, rd, er);
    access(0, 1, 1, 0, BASE + 10, 32'h0000_1234, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_lat: got %0d want 3", lat); end
    access(1, 0, 0, 0, BASE + 8, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL sh_data: got %h want 1234beef", rd); end
    // Upper garbage in w_data must not leak into the merged byte.
    access(0, 1, 1, 1, BASE + 11, 32'hFFFF_FF5A, lat, rd, er);
    access(1, 0, 0, 0, BASE + 8, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h5A34BEEF) begin errors++; $display("FAIL sb_lane3_data: got %h want 5a34beef", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    access(0, 1, 0, 0, BASE, 32'hCAFEF00D, lat, rd, er);
    access(1, 0, 0, 0, BASE, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL w0_load: got %h want cafef00d", rd); end
    access(1, 0, 0, 0, BASE + 2, 32'h0, lat, rd, er);
    checks++; if (lat !== ERR_LAT) begin errors++; $display("FAIL misalign_load_lat: got %0d want %0d", lat, ERR_LAT); end
    checks++; if (er !== ERR_FLAG) begin errors++; $display("FAIL misalign_load_err: got %b want %b", er, ERR_FLAG); end
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_load_data: got %h want cafef00d", rd); end
    access(0, 1, 0, 0, BASE + 4 * DEPTH, 32'h55555555, lat, rd, er);
    checks++; if (lat !== ERR_LAT) begin errors++; $display("FAIL range_store_lat: got %0d want %0d", lat, ERR_LAT); end
    checks++; if (er !== ERR_FLAG) begin errors++; $display("FAIL range_store_err: got %b want %b", er, ERR_FLAG); end
    access(1, 0, 0, 0, BASE, 32'h0, lat, rd, er);
    checks++; if (rd !== W0_AFTER) begin errors++; $display("FAIL range_store_w0: got %h want %h", rd, W0_AFTER); end
    access(0, 1, 0, 0, BASE + 16, 32'hAABBCCDD, lat, rd, er);
    access(0, 1, 1, 0, BASE + 17, 32'h0000_7777, lat, rd, er);
    checks++; if (lat !== SH_LAT) begin errors++; $display("FAIL misalign_sh_lat: got %0d want %0d", lat, SH_LAT); end
    checks++; if (er !== ERR_FLAG) begin errors++; $display("FAIL misalign_sh_err: got %b want %b", er, ERR_FLAG); end
    access(1, 0, 0, 0, BASE + 16, 32'h0, lat, rd, er);
    checks++; if (rd !== W16_AFTER) begin errors++; $display("FAIL misalign_sh_word: got %h want %h", rd, W16_AFTER); end
  endtask

  task automatic test_back_to_back();
    int lat, ready_cnt; logic [31:0] rd; logic er;
    @(negedge clk);
    data_addr = BASE + 8; dmem_r = 1'b1;
    lat = 0; ready_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (dmem_ready) begin
        ready_cnt++;
        if (lat == 0) lat = i;
      end
      if (lat != 0 && i == lat + 2) dmem_r = 1'b0;
    end
    idle_inputs();
    checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL held_ready_count: got %0d want 1", ready_cnt); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL held_lat: got %0d want 2", lat); end
    access(0, 1, 0, 0, BASE + 20, 32'h0, lat, rd, er);
    access(1, 1, 0, 0, BASE + 20, 32'h0BADCAFE, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL both_lat: got %0d want 2", lat); end
    access(1, 0, 0, 0, BASE + 20, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL both_is_store: got %h want 0badcafe", rd); end
  endtask

  task automatic test_reset_mid_rmw();
    int lat, ready_cnt; logic [31:0] rd; logic er;
    access(0, 1, 0, 0, BASE + 12, 32'h11223344, lat, rd, er);
    access(1, 0, 0, 0, BASE + 12, 32'h0, lat, rd, er);
    @(negedge clk);
    data_addr = BASE + 12; w_data = 32'h0000_00EE;
    dmem_w = 1'b1; special_store_signal = 1'b1; store_byte = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", dmem_data); end
    checks++; if (dmem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", dmem_ready); end
    idle_inputs();
    ready_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (dmem_ready) ready_cnt++;
    end
    checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", ready_cnt); end
    @(negedge clk) rstn = 1'b1;
    access(1, 0, 0, 0, BASE + 12, 32'h0, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_reload_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL midrst_word: got %h want 11223344", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
